// File: rtl/arm_cond_pkg.sv
// Shared definitions for the conditional issue queue.
//   - 4-bit ARM condition encodings COND_EQ..COND_NV
//   - NZCV bit positions within a 4-bit flag vector
//   - issue FSM state type
//   - cond_pass(): evaluates a condition field against an NZCV value
package arm_cond_pkg;

    localparam logic [3:0] COND_EQ = 4'h0;
    localparam logic [3:0] COND_NE = 4'h1;
    localparam logic [3:0] COND_CS = 4'h2;
    localparam logic [3:0] COND_CC = 4'h3;
    localparam logic [3:0] COND_MI = 4'h4;
    localparam logic [3:0] COND_PL = 4'h5;
    localparam logic [3:0] COND_VS = 4'h6;
    localparam logic [3:0] COND_VC = 4'h7;
    localparam logic [3:0] COND_HI = 4'h8;
    localparam logic [3:0] COND_LS = 4'h9;
    localparam logic [3:0] COND_GE = 4'hA;
    localparam logic [3:0] COND_LT = 4'hB;
    localparam logic [3:0] COND_GT = 4'hC;
    localparam logic [3:0] COND_LE = 4'hD;
    localparam logic [3:0] COND_AL = 4'hE;
    localparam logic [3:0] COND_NV = 4'hF;

    localparam int unsigned FLAG_N = 3;
    localparam int unsigned FLAG_Z = 2;
    localparam int unsigned FLAG_C = 1;
    localparam int unsigned FLAG_V = 0;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_EVAL  = 2'd1,
        S_WAIT  = 2'd2
    } state_e;

    function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v, pass;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            COND_AL: pass = 1'b1;
            default: pass = 1'b0; // NV is never executed
        endcase
        return pass;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, DEPTH entries of WIDTH bits (DEPTH a power of two).
// Ports:
//   clk, rst_n         clock, async active-low reset (empties the FIFO)
//   push_i, wdata_i    write request and data (ignored when full)
//   pop_i, rdata_o     read request (ignored when empty), head entry
//   full_o, empty_o    occupancy flags
//   count_o            current number of entries
module sync_fifo #(
    parameter int unsigned WIDTH = 33,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        if (do_push && !do_pop) begin
            count_d = count_q + 1'b1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
        end
    end

    // Storage needs no reset: entries are only read once the count covers them.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/cond_issue_queue.sv
// Conditional issue queue: buffers instruction words, evaluates each head word's
// condition field against a local NZCV copy, issues passing words through a
// registered valid/ready output and squashes failing ones. Conditional words
// wait while flag-setting instructions are still in flight.
// Ports:
//   clk, rst_n                         clock, async active-low reset
//   in_valid/in_ready/in_data/in_sets_flags   upstream push interface
//   out_valid/out_ready/out_data/out_sets_flags  registered issue interface
//   flag_wr, flag_in                   flag write-back from execute
//   flags                              current NZCV copy
// Optional (macro ISSUER_STATS_EN): issued_cnt, squashed_cnt wrapping counters.
module cond_issue_queue
    import arm_cond_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned PEND_MAX = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sets_flags,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_sets_flags,
    input  logic             flag_wr,
    input  logic [3:0]       flag_in,
    output logic [3:0]       flags
`ifdef ISSUER_STATS_EN
    ,
    output logic [15:0]      issued_cnt,
    output logic [15:0]      squashed_cnt
`endif
);

    localparam int unsigned PW = $clog2(PEND_MAX + 1);
    localparam logic [PW-1:0] PendMaxC = PW'(PEND_MAX);

    state_e           state_q, state_d;
    logic [PW-1:0]    pend_q, pend_d;
    logic [3:0]       flags_q;
    logic             out_valid_q, out_sf_q;
    logic [WIDTH-1:0] out_data_q;

    logic [WIDTH:0]   head_word;
    logic [3:0]       head_cond;
    logic             head_sf;
    logic             fifo_full, fifo_empty;
    logic [$clog2(DEPTH):0] fifo_count;
    logic             push, pop, load, squash, out_free, pend_inc, pend_dec;

    sync_fifo #(
        .WIDTH (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .wdata_i ({in_sets_flags, in_data}),
        .pop_i   (pop),
        .rdata_o (head_word),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign in_ready  = !fifo_full;
    assign push      = in_valid && !fifo_full;
    assign head_sf   = head_word[WIDTH];
    assign head_cond = head_word[WIDTH-1 -: 4];
    assign out_free  = !out_valid_q || out_ready;

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        load    = 1'b0;
        squash  = 1'b0;
        unique case (state_q)
            S_EMPTY: begin
                if (push) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (!fifo_empty) begin
                    // Conditional words never evaluate while flag writers are in flight.
                    if (head_cond != COND_AL && pend_q != '0) begin
                        state_d = S_WAIT;
                    end else if (!cond_pass(head_cond, flags_q)) begin
                        squash = 1'b1;
                        pop    = 1'b1;
                    end else if (out_free && !(head_sf && pend_q == PendMaxC)) begin
                        load = 1'b1;
                        pop  = 1'b1;
                    end
                end
                if (pop && fifo_count == 1 && !push) state_d = S_EMPTY;
            end
            S_WAIT: begin
                if (pend_q == '0) state_d = S_EVAL;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    assign pend_inc = load && head_sf;
    assign pend_dec = flag_wr && pend_q != '0;

    always_comb begin
        pend_d = pend_q;
        if (pend_inc && !pend_dec) begin
            pend_d = pend_q + 1'b1;
        end else if (!pend_inc && pend_dec) begin
            pend_d = pend_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_EMPTY;
            pend_q      <= '0;
            flags_q     <= 4'b0000;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sf_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            if (flag_wr) flags_q <= flag_in;
            if (load) begin
                out_valid_q <= 1'b1;
                out_data_q  <= head_word[WIDTH-1:0];
                out_sf_q    <= head_sf;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_data       = out_data_q;
    assign out_sets_flags = out_sf_q;
    assign flags          = flags_q;

`ifdef ISSUER_STATS_EN
    logic [15:0] issued_q, squashed_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issued_q   <= '0;
            squashed_q <= '0;
        end else begin
            if (load)   issued_q   <= issued_q + 16'd1;
            if (squash) squashed_q <= squashed_q + 16'd1;
        end
    end

    assign issued_cnt   = issued_q;
    assign squashed_cnt = squashed_q;
`else
    logic unused_squash;
    assign unused_squash = squash;
`endif

endmodule
